// File: rtl/relu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | relu_pkg : shared FSM encoding, width defaults and clog2 helper           |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package relu_pkg;

    localparam int         c_DATA_W_DEF = 32;
    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_BURST   = 1'b1;

    // Never returns less than 1 so an index port always has at least one bit
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_clamp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | relu_clamp : combinational sign clamp, negative words become zero         |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module relu_clamp
    import relu_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    assign o_data = i_data[DATA_W-1] ? '0 : i_data;

endmodule
`default_nettype wire

// File: rtl/relu_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | relu_sched : round-robin burst scheduler feeding one ReLU output register |
// |              Optional clip counter enabled by RELU_SCHED_STATS_EN         |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module relu_sched
    import relu_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [clog2(N_REQ)-1:0]   out_id,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy
`ifdef RELU_SCHED_STATS_EN
    ,
    input  logic                      clip_clr,
    output logic [31:0]               clip_cnt
`endif
);

    localparam int c_ID_W = clog2(N_REQ);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_ID_W-1:0] r_grant;
    logic [c_ID_W-1:0] r_last_grant;
    logic [c_ID_W-1:0] w_sel;
    logic              w_any_valid;
    logic              w_gnt_valid;
    logic              w_gnt_last;
    logic [DATA_W-1:0] w_gnt_data;
    logic [DATA_W-1:0] w_relu;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_burst_done;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [c_ID_W-1:0] r_out_id;
    logic              r_out_last;

    // Two passes: indices above the last grant first, then wrap to the bottom
    always_comb begin
        w_sel       = r_last_grant;
        w_any_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any_valid && req_valid[i] && (c_ID_W'(i) > r_last_grant)) begin
                w_sel       = c_ID_W'(i);
                w_any_valid = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any_valid && req_valid[i]) begin
                w_sel       = c_ID_W'(i);
                w_any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        w_gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == c_ID_W'(i)) begin
                w_gnt_valid = req_valid[i];
                w_gnt_last  = req_last[i];
                w_gnt_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_slot_free  = !r_out_valid || out_ready;
    assign w_accept     = (r_state == c_ST_BURST) && w_gnt_valid && w_slot_free;
    assign w_burst_done = w_accept && w_gnt_last;

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_valid) w_state_nxt = c_ST_BURST;
            end
            c_ST_BURST: begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (r_grant == c_ID_W'(i)) req_ready[i] = w_slot_free;
                end
                if (w_burst_done) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_ID_W'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_ST_IDLE) && w_any_valid) r_grant <= w_sel;
            if (w_burst_done) r_last_grant <= r_grant;
        end
    end

    relu_clamp #(
        .DATA_W (DATA_W)
    ) u_clamp (
        .i_data (w_gnt_data),
        .o_data (w_relu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_relu;
            r_out_id    <= r_grant;
            r_out_last  <= w_gnt_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_last  = r_out_last;
    assign busy      = (r_state == c_ST_BURST);

`ifdef RELU_SCHED_STATS_EN
    logic [31:0] r_clip_cnt;

    // A clear in the same cycle as a clipped beat leaves the counter at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clip_cnt <= '0;
        end else if (clip_clr) begin
            r_clip_cnt <= '0;
        end else if (w_accept && w_gnt_data[DATA_W-1] && (r_clip_cnt != 32'hFFFF_FFFF)) begin
            r_clip_cnt <= r_clip_cnt + 32'd1;
        end
    end

    assign clip_cnt = r_clip_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_relu_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_relu_sched : randomized and directed bench for relu_sched              |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_relu_sched;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int ID_W = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [ID_W-1:0]   out_id;
    logic              out_last;
    logic              out_ready;
    logic              busy;
`ifdef RELU_SCHED_STATS_EN
    logic              clip_clr;
    logic [31:0]       clip_cnt;
`endif

    int n_pass;
    int n_checks;

    typedef struct {
        logic [W-1:0] d;
        int           id;
        bit           last;
    } exp_t;

    logic [W-1:0] bd [N][64];
    bit           bl [N][64];
    int           bn [N];
    exp_t         exp_q [$];

    relu_sched #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef RELU_SCHED_STATS_EN
        ,
        .clip_clr  (clip_clr),
        .clip_cnt  (clip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] relu_ref(input logic signed [W-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b0;
`ifdef RELU_SCHED_STATS_EN
        clip_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, out_valid, out_data, out_id, out_last, busy} !== '0)
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h id=%0d l=%b busy=%b, want all 0",
                     req_ready, out_valid, out_data, out_id, out_last, busy);
        else n_pass++;
`ifdef RELU_SCHED_STATS_EN
        n_checks++;
        if (clip_cnt !== 32'd0) $display("FAIL reset_clip_cnt: got %0d want 0", clip_cnt);
        else n_pass++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0001; req_data[0 +: W] = 32'h0000_0005; req_last = '0; out_ready = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, busy} !== 5'b0) $display("FAIL single_bubble: got rdy=%b busy=%b want 0", req_ready, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({req_ready, busy, out_valid} !== 6'b0001_1_0)
            $display("FAIL single_grant: got rdy=%b busy=%b v=%b want 0001 1 0", req_ready, busy, out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd0, 1'b0, 32'h5})
            $display("FAIL single_beat0: got v=%b id=%0d l=%b d=%h want 1 0 0 00000005", out_valid, out_id, out_last, out_data);
        else n_pass++;
        req_data[0 +: W] = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd0, 1'b0, 32'h0})
            $display("FAIL single_beat1: got v=%b id=%0d l=%b d=%h want 1 0 0 00000000", out_valid, out_id, out_last, out_data);
        else n_pass++;
        req_data[0 +: W] = 32'h7FFF_FFFF; req_last = 4'b0001;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_id, out_last, out_data, busy} !== {1'b1, 2'd0, 1'b1, 32'h7FFF_FFFF, 1'b0})
            $display("FAIL single_beat2: got v=%b id=%0d l=%b d=%h busy=%b want 1 0 1 7fffffff 0",
                     out_valid, out_id, out_last, out_data, busy);
        else n_pass++;
        req_valid = '0; req_last = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_drain: got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 4'b0100; req_data[2*W +: W] = 32'h0000_1234; req_last = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, busy} !== 2'b11) $display("FAIL rstmid_setup: got v=%b busy=%b want 1 1", out_valid, busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, out_valid, out_data, out_id, out_last, busy} !== '0)
            $display("FAIL rstmid_async: got rdy=%b v=%b d=%h id=%0d l=%b busy=%b want all 0",
                     req_ready, out_valid, out_data, out_id, out_last, busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        for (int r = 0; r < N; r++) req_data[r*W +: W] = 32'h100 + r;
        @(negedge clk);
        n_checks++;
        if ({req_ready, busy} !== 5'b0001_1) $display("FAIL rstmid_first_grant: got rdy=%b busy=%b want 0001 1", req_ready, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 32'h100})
            $display("FAIL rstmid_first_beat: got v=%b id=%0d d=%h want 1 0 00000100", out_valid, out_id, out_data);
        else n_pass++;
        req_valid = '0; req_last = '0;
        @(negedge clk);
    endtask

    task automatic test_gap();
        @(negedge clk);
        req_valid = 4'b0110; req_last = 4'b0100; out_ready = 1'b1;
        req_data[1*W +: W] = 32'h0000_0011;
        req_data[2*W +: W] = 32'h0000_0C0C;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL gap_grant1: got rdy=%b want 0010", req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd1, 1'b0, 32'h11})
            $display("FAIL gap_beatA: got v=%b id=%0d l=%b d=%h want 1 1 0 00000011", out_valid, out_id, out_last, out_data);
        else n_pass++;
        req_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({req_ready[2], busy} !== 2'b01) $display("FAIL gap_stall: got rdy2=%b busy=%b want 0 1", req_ready[2], busy);
            else n_pass++;
        end
        req_valid[1] = 1'b1; req_last[1] = 1'b1; req_data[1*W +: W] = 32'hFFFF_0000;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL gap_resume: got rdy=%b want 0010", req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_id, out_last, out_data, busy} !== {1'b1, 2'd1, 1'b1, 32'h0, 1'b0})
            $display("FAIL gap_beatB: got v=%b id=%0d l=%b d=%h busy=%b want 1 1 1 00000000 0",
                     out_valid, out_id, out_last, out_data, busy);
        else n_pass++;
        req_valid[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0100) $display("FAIL gap_grant2: got rdy=%b want 0100", req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd2, 1'b1, 32'h0C0C})
            $display("FAIL gap_beatC: got v=%b id=%0d l=%b d=%h want 1 2 1 00000c0c", out_valid, out_id, out_last, out_data);
        else n_pass++;
        req_valid = '0; req_last = '0;
        @(negedge clk);
    endtask

    task automatic test_random(input int bursts, input int gap_pct, input int stall_pct, input bit check_tput);
        int           bp [N];
        int           mp [N];
        int           rb [N];
        bit           inb [N];
        int           lastg, pick, len, total_beats, total_bursts, cycles, last_in;
        bit           found, prev_hold, prev_done;
        logic [W-1:0] hd;
        logic [ID_W-1:0] hid;
        logic         hl;
        exp_t         e;

        req_valid = '0; req_last = '0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        total_beats = 0; total_bursts = 0;
        exp_q.delete();
        for (int r = 0; r < N; r++) begin
            bn[r] = 0; bp[r] = 0; mp[r] = 0; inb[r] = 1'b0; rb[r] = bursts;
            for (int b = 0; b < bursts; b++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    bd[r][bn[r]] = $urandom;
                    bl[r][bn[r]] = (k == len - 1);
                    bn[r]++;
                    total_beats++;
                end
                total_bursts++;
            end
        end

        // Every requester with work left is waiting at each arbitration, so the
        // service order is plain round robin over requesters with bursts left.
        lastg = N - 1;
        for (int t = 0; t < total_bursts; t++) begin
            found = 1'b0; pick = 0;
            for (int off = 1; off <= N; off++) begin
                if (!found && rb[(lastg + off) % N] > 0) begin
                    pick = (lastg + off) % N; found = 1'b1;
                end
            end
            do begin
                e.d = relu_ref(bd[pick][mp[pick]]); e.id = pick; e.last = bl[pick][mp[pick]];
                exp_q.push_back(e);
                mp[pick]++;
            end while (!e.last);
            rb[pick]--;
            lastg = pick;
        end

        cycles = 0; last_in = 0; prev_hold = 1'b0; prev_done = 1'b0;
        hd = '0; hid = '0; hl = 1'b0;
        while (exp_q.size() > 0 && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            for (int r = 0; r < N; r++) begin
                if (bp[r] < bn[r]) begin
                    req_valid[r] = inb[r] ? ($urandom_range(0, 99) >= gap_pct) : 1'b1;
                    req_data[r*W +: W] = bd[r][bp[r]];
                    req_last[r] = bl[r][bp[r]];
                end else begin
                    req_valid[r] = 1'b0;
                    req_data[r*W +: W] = $urandom;
                    req_last[r] = 1'($urandom_range(0, 1));
                end
            end
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            #1;
            n_checks++;
            if ($countones(req_ready) > 1) $display("FAIL rnd_ready_onehot: got rdy=%b want at most one bit", req_ready);
            else n_pass++;
            if (prev_hold) begin
                n_checks++;
                if ({out_valid, out_data, out_id, out_last} !== {1'b1, hd, hid, hl})
                    $display("FAIL rnd_hold: got v=%b d=%h id=%0d l=%b want 1 %h %0d %b",
                             out_valid, out_data, out_id, out_last, hd, hid, hl);
                else n_pass++;
            end
            if (prev_done) begin
                n_checks++;
                if ({req_ready, busy} !== 5'b0) $display("FAIL rnd_bubble: got rdy=%b busy=%b want 0 0", req_ready, busy);
                else n_pass++;
            end
            prev_hold = out_valid && !out_ready;
            hd = out_data; hid = out_id; hl = out_last;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_extra_beat: got id=%0d d=%h want no beat", out_id, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_id, out_last} !== {e.d, ID_W'(e.id), e.last})
                        $display("FAIL rnd_beat: got d=%h id=%0d l=%b want d=%h id=%0d l=%b",
                                 out_data, out_id, out_last, e.d, e.id, e.last);
                    else n_pass++;
                end
            end
            prev_done = 1'b0;
            for (int r = 0; r < N; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    inb[r] = !req_last[r];
                    if (req_last[r]) prev_done = 1'b1;
                    bp[r]++;
                    last_in = cycles;
                end
            end
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL rnd_timeout: got %0d beats outstanding want 0", exp_q.size());
        end
        if (check_tput) begin
            n_checks++;
            if (last_in !== total_beats + total_bursts)
                $display("FAIL rnd_throughput: got last accept at cycle %0d want %0d", last_in, total_beats + total_bursts);
            else n_pass++;
        end
        req_valid = '0; req_last = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef RELU_SCHED_STATS_EN
    task automatic test_stats();
        logic [W-1:0] beats [11];
        int           neg, k, budget;
        bit           checked;
        req_valid = '0; req_last = '0; clip_clr = 1'b0; out_ready = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        neg = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1 || i == 4 || i == 6 || i == 9) beats[i] = 32'h8000_0000 | $urandom;
            else beats[i] = $urandom & 32'h7FFF_FFFF;
            if ($signed(beats[i]) < 0) neg++;
        end
        beats[10] = 32'h8000_0001;
        k = 0; budget = 0; checked = 1'b0;
        while (k < 11 && budget < 100) begin
            @(negedge clk);
            budget++;
            if (k == 10 && !checked) begin
                checked = 1'b1;
                n_checks++;
                if (clip_cnt !== 32'(neg)) $display("FAIL stats_count: got %0d want %0d", clip_cnt, neg);
                else n_pass++;
            end
            req_valid = 4'b0001;
            req_data[0 +: W] = beats[k];
            req_last = {3'b000, (k == 10)};
            clip_clr = (k == 10);
            #1;
            if (req_ready[0]) k++;
        end
        @(negedge clk);
        clip_clr = 1'b0; req_valid = '0; req_last = '0;
        n_checks++;
        if (k != 11) $display("FAIL stats_timeout: got %0d beats accepted want 11", k);
        else if (clip_cnt !== 32'd0) $display("FAIL stats_clear: got %0d want 0", clip_cnt);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        n_pass   = 0;
        n_checks = 0;
        test_reset();
        test_single();
        test_reset_mid();
        test_gap();
        test_random(6, 0, 0, 1'b1);
        test_random(6, 30, 40, 1'b0);
        test_random(5, 50, 70, 1'b0);
`ifdef RELU_SCHED_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
